// File: rtl/gf180mcu_osu_sc_gp9t3v3_ro_freq_meter.sv
// gf180mcu_osu_sc_gp9t3v3_ro_freq_meter: counts ring-oscillator rising edges over a gate window of CLK cycles
// CLK/RST: clock and synchronous active-high reset
// RO: asynchronous oscillator input; START/GATE: launch a G-cycle window (IDLE only)
// ACK: consumer takes result (DONE only); BUSY: ARM or COUNT; VALID: result held in DONE
// COUNT/OVF: saturating edge count and sticky overflow flag
module gf180mcu_osu_sc_gp9t3v3_ro_freq_meter #(
  parameter int GATE_W = 16,
  parameter int CNT_W = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RO,
  input  logic              START,
  input  logic [GATE_W-1:0] GATE,
  input  logic              ACK,
  output logic              BUSY,
  output logic              VALID,
  output logic [CNT_W-1:0]  COUNT,
  output logic              OVF
);
  typedef enum logic [1:0] {S_IDLE, S_ARM, S_COUNT, S_DONE} state_t;
  state_t state, next;
  logic [SYNC_STAGES-1:0] sync;
  logic sync_d;
  logic rise;
  logic [GATE_W-1:0] g;
  assign rise = sync[SYNC_STAGES-1] & ~sync_d;
  assign BUSY = (state == S_ARM) || (state == S_COUNT);
  assign VALID = state == S_DONE;
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync <= '0;
      sync_d <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], RO};
      sync_d <= sync[SYNC_STAGES-1];
    end
  end
  always_ff @(posedge CLK) state <= RST ? S_IDLE : next;
  // g holds the cycles still left in the window; g==1 marks the last COUNT cycle
  always_comb begin
    next = state;
    next = state == S_IDLE  ? (START ? S_ARM : S_IDLE) :
           state == S_ARM   ? (g != '0 ? S_COUNT : S_DONE) :
           state == S_COUNT ? (g == GATE_W'(1) ? S_DONE : S_COUNT) :
                              (ACK ? S_IDLE : S_DONE);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      g <= '0;
      COUNT <= '0;
      OVF <= 1'b0;
    end else if (state == S_IDLE && START) begin
      g <= GATE;
      COUNT <= '0;
      OVF <= 1'b0;
    end else if (state == S_COUNT) begin
      g <= g - GATE_W'(1);
      if (rise) begin
        if (&COUNT) OVF <= 1'b1;
        else COUNT <= COUNT + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3_ro_freq_meter.sv
// tb_gf180mcu_osu_sc_gp9t3v3_ro_freq_meter: directed self-checking bench for the RO frequency meter
module tb_gf180mcu_osu_sc_gp9t3v3_ro_freq_meter;
  logic clk = 0, rst = 1, ro = 0;
  logic [1:0] start = 0, ack = 0;
  logic [15:0] gate = 0;
  logic busy1, valid1, ovf1, busy2, valid2, ovf2;
  logic [19:0] count1;
  logic [3:0] count2;
  int ro_div = 8, ph = 0, passed = 0, total = 0, n;
  always #5 clk = ~clk;
  gf180mcu_osu_sc_gp9t3v3_ro_freq_meter u1 (
    .CLK(clk), .RST(rst), .RO(ro), .START(start[0]), .GATE(gate), .ACK(ack[0]),
    .BUSY(busy1), .VALID(valid1), .COUNT(count1), .OVF(ovf1));
  gf180mcu_osu_sc_gp9t3v3_ro_freq_meter #(.CNT_W(4)) u2 (
    .CLK(clk), .RST(rst), .RO(ro), .START(start[1]), .GATE(gate), .ACK(ack[1]),
    .BUSY(busy2), .VALID(valid2), .COUNT(count2), .OVF(ovf2));
  initial forever begin
    @(negedge clk);
    if (ro_div != 0) begin
      ph++;
      if (ph >= ro_div / 2) begin
        ro = ~ro;
        ph = 0;
      end
    end
  end
  task check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask
  function automatic logic vld(input int s);
    return s != 0 ? valid2 : valid1;
  endfunction
  task pulse_start(input int s, input logic [15:0] g);
    gate = g;
    start[s] = 1;
    @(negedge clk);
    start[s] = 0;
  endtask
  task pulse_ack(input int s);
    ack[s] = 1;
    @(negedge clk);
    ack[s] = 0;
  endtask
  task run_wait(input int s, input int budget, output int k);
    k = 0;
    while (!vld(s) && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask
  initial begin
    start = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_outs", {busy1, valid1, ovf1, busy2, valid2, ovf2}, 0);
      check("rst_count", count1 + count2, 0);
    end
    start = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("idle_after_rst", {busy1, valid1}, 0);
    pulse_start(0, 800);
    check("busy_arm", busy1, 1);
    run_wait(0, 900, n);
    check("g800_latency", n, 801);
    check("g800_count_range", int'(count1 >= 99 && count1 <= 101), 1);
    check("g800_ovf", ovf1, 0);
    pulse_ack(0);
    check("ack_clears_valid", valid1, 0);
    check("count_held_idle", int'(count1 >= 99 && count1 <= 101), 1);
    pulse_start(0, 0);
    check("g0_busy_t1", busy1, 1);
    run_wait(0, 10, n);
    check("g0_latency", n, 1);
    check("g0_busy_done", busy1, 0);
    check("g0_count", count1, 0);
    check("g0_ovf", ovf1, 0);
    pulse_ack(0);
    ro_div = 4;
    pulse_start(1, 100);
    run_wait(1, 200, n);
    check("sat_latency", n, 101);
    check("sat_count", count2, 15);
    check("sat_ovf", ovf2, 1);
    pulse_ack(1);
    ro_div = 0;
    pulse_start(1, 100);
    check("start_clears_count", count2, 0);
    check("start_clears_ovf", ovf2, 0);
    run_wait(1, 200, n);
    check("static_count", count2, 0);
    check("static_ovf", ovf2, 0);
    pulse_ack(1);
    ro_div = 8;
    pulse_start(0, 20);
    repeat (5) @(negedge clk);
    pulse_start(0, 3);
    run_wait(0, 100, n);
    check("busy_start_ignored", n, 15);
    pulse_start(0, 3);
    check("done_start_ignored", valid1, 1);
    gate = 3;
    start[0] = 1;
    ack[0] = 1;
    @(negedge clk);
    start[0] = 0;
    ack[0] = 0;
    check("ack_start_valid", valid1, 0);
    repeat (3) @(negedge clk);
    check("ack_start_no_run", {busy1, valid1}, 0);
    pulse_start(0, 1000);
    repeat (500) @(negedge clk);
    check("mid_busy", busy1, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("mid_rst_outs", {busy1, valid1, ovf1}, 0);
    check("mid_rst_count", count1, 0);
    pulse_start(0, 8);
    run_wait(0, 50, n);
    check("rerun_latency", n, 9);
    check("rerun_count_range", int'(count1 >= 0 && count1 <= 2), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
